img_word_packer: RTL and testbench

Output-side drain for the edge-detection pipeline: reads 8-bit result pixels from the pipeline's output FIFO and packs them four per 32-bit word, with end-of-line and end-of-frame tags, into a downstream word FIFO for a memory or bus writer. It tracks pixel x/y position per frame, pads the final word of each row when WIDTH is not a multiple of 4, and pulses a frame-done strobe with a running frame count.

---
 rtl/img_word_packer.sv | 191 +++++++++++++++++++
 tb/tb_img_word_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_word_packer.sv
// ---------------------------------------------------------------------------
// img_word_packer
//
// Output-side drain for the edge-detection pipeline. Pops 8-bit result pixels
// from a first-word-fall-through pixel FIFO, packs them four per 32-bit word
// (first pixel in bits [7:0]) and pushes each word, tagged with end-of-line
// and end-of-frame flags, into a downstream word FIFO. Pixel x/y position is
// derived purely from the number of pixels popped since reset. The last word
// of a row is zero-padded when WIDTH is not a multiple of four.
//
// Parameters:
//   WIDTH        pixels per row (>= 1)
//   HEIGHT       rows per frame (>= 1)
//
// Ports:
//   clock        single clock, all logic on the rising edge
//   reset        synchronous, active-low; clears all state
//   in_empty     upstream pixel FIFO empty
//   in_dout      upstream pixel, valid whenever in_empty is low
//   in_rd_en     pops the upstream pixel FIFO
//   out_full     downstream word FIFO full
//   out_wr_en    writes out_din into the downstream FIFO
//   out_din      [33] end-of-frame, [32] end-of-line, [31:0] packed pixels
//   frame_done   one-cycle pulse in the cycle after the end-of-frame write
//   frame_count  completed frames since reset, wraps 0xFFFF -> 0
//   checksum     per-frame pixel sum, or 0 when the checksum is compiled out
//
// Build option:
//   PACKER_CHECKSUM_EN  when defined, a 32-bit accumulator sums every popped
//                       pixel and the total is published on each end-of-frame
//                       write; when undefined, checksum is tied to zero.
// ---------------------------------------------------------------------------
module img_word_packer #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_empty,
    input  logic [7:0]  in_dout,
    output logic        in_rd_en,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [33:0] out_din,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [31:0] checksum
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic {
        S_FILL,
        S_EMIT
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [1:0]    lane;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [31:0]   word;
    logic          eol_flag;
    logic          eof_flag;

    logic          row_end;
    logic          word_close;
    logic          frame_end;

    // The captured pixel closes the word when it fills the top lane or is the
    // last pixel of a row; a row-closing word may leave upper lanes at zero.
    assign row_end    = (x == X_LAST);
    assign word_close = (lane == 2'd3) || row_end;
    assign frame_end  = row_end && (y == Y_LAST);

    // The packed word and its tags are held in registers so out_din stays
    // stable for as long as the downstream FIFO keeps us waiting.
    assign out_din = {eof_flag, eol_flag, word};

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave S_FILL when a closing pixel is popped, leave
    // S_EMIT once the held word has been written.
    always_comb begin
        state_next = state;
        case (state)
            S_FILL: if (in_rd_en && word_close) state_next = S_EMIT;
            S_EMIT: if (out_wr_en)              state_next = S_FILL;
            default: state_next = S_FILL;
        endcase
    end

    // Output logic: pops only while filling, writes only while emitting, so
    // the two enables can never be high together. Both are held low while
    // reset is asserted.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        if (reset) begin
            case (state)
                S_FILL:  in_rd_en  = !in_empty;
                S_EMIT:  out_wr_en = !out_full;
                default: ;
            endcase
        end
    end

    // Packing datapath and pixel position. Position only moves on a pop, so a
    // stall on either side leaves lane/x/y untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lane     <= 2'd0;
            x        <= '0;
            y        <= '0;
            word     <= 32'd0;
            eol_flag <= 1'b0;
            eof_flag <= 1'b0;
        end else if (in_rd_en) begin
            word[{lane, 3'b000} +: 8] <= in_dout;
            if (word_close) begin
                lane     <= 2'd0;
                eol_flag <= row_end;
                eof_flag <= frame_end;
                if (row_end) begin
                    x <= '0;
                    y <= frame_end ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else begin
                lane <= lane + 2'd1;
                x    <= x + 1'b1;
            end
        end else if (out_wr_en) begin
            // Clearing on write is what guarantees zero padding in the
            // unused lanes of the next row-closing word.
            word     <= 32'd0;
            eol_flag <= 1'b0;
            eof_flag <= 1'b0;
        end
    end

    // Frame bookkeeping: the done strobe is registered so it lands in the
    // cycle after the end-of-frame word leaves.
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_done <= out_wr_en && eof_flag;
            if (out_wr_en && eof_flag) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef PACKER_CHECKSUM_EN
    logic [31:0] accum;
    logic [31:0] checksum_q;

    // Pops and writes are mutually exclusive, so by the time the end-of-frame
    // word is written every pixel of the frame is already in the accumulator.
    always_ff @(posedge clock) begin
        if (!reset) begin
            accum      <= 32'd0;
            checksum_q <= 32'd0;
        end else if (in_rd_en) begin
            accum <= accum + {24'd0, in_dout};
        end else if (out_wr_en && eof_flag) begin
            checksum_q <= accum;
            accum      <= 32'd0;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_img_word_packer.sv
// ---------------------------------------------------------------------------
// tb_img_word_packer
//
// Drives two packer instances (8x2 and 6x1 frames) from emulated pixel FIFOs
// and checks every written word, frame strobe, frame count and checksum
// against a pixel-position model, plus literal expectations for the words.
// ---------------------------------------------------------------------------
module tb_img_word_packer;

    localparam int N  = 256;
    localparam int W0 = 8;
    localparam int H0 = 2;
    localparam int W1 = 6;
    localparam int H1 = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        in_empty    [2] = '{1'b1, 1'b1};
    logic [7:0]  in_dout     [2] = '{8'd0, 8'd0};
    logic        in_rd_en    [2];
    logic        out_full    [2] = '{1'b0, 1'b0};
    logic        out_wr_en   [2];
    logic [33:0] out_din     [2];
    logic        frame_done  [2];
    logic [15:0] frame_count [2];
    logic [31:0] checksum    [2];

    // Emulated upstream FIFOs and the model's expected-word queues.
    logic [7:0]  in_buf   [2][N];
    int          in_head  [2] = '{0, 0};
    int          in_tail  [2] = '{0, 0};
    logic [33:0] exp_word [2][N];
    logic [15:0] exp_fc   [2][N];
    logic [31:0] exp_chk  [2][N];
    int          exp_head [2] = '{0, 0};
    int          exp_tail [2] = '{0, 0};

    int          m_count  [2] = '{0, 0};
    logic [31:0] m_word   [2] = '{32'd0, 32'd0};
    logic [31:0] m_sum    [2] = '{32'd0, 32'd0};
    logic [15:0] m_frames [2] = '{16'd0, 16'd0};

    logic [33:0] log_word [2][N];
    int          log_cnt  [2] = '{0, 0};

    logic        done_pending [2] = '{1'b0, 1'b0};
    logic [15:0] fc_hold      [2] = '{16'd0, 16'd0};
    logic [31:0] chk_hold     [2] = '{32'd0, 32'd0};

    logic        gap_mode  [2] = '{1'b0, 1'b0};
    logic        full_hold [2] = '{1'b0, 1'b0};
    logic        toggle    [2] = '{1'b0, 1'b0};
    logic        checking = 1'b0;

    int passed = 0;
    int total  = 0;

    img_word_packer #(.WIDTH(W0), .HEIGHT(H0)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .in_empty    (in_empty[0]),
        .in_dout     (in_dout[0]),
        .in_rd_en    (in_rd_en[0]),
        .out_full    (out_full[0]),
        .out_wr_en   (out_wr_en[0]),
        .out_din     (out_din[0]),
        .frame_done  (frame_done[0]),
        .frame_count (frame_count[0]),
        .checksum    (checksum[0])
    );

    img_word_packer #(.WIDTH(W1), .HEIGHT(H1)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .in_empty    (in_empty[1]),
        .in_dout     (in_dout[1]),
        .in_rd_en    (in_rd_en[1]),
        .out_full    (out_full[1]),
        .out_wr_en   (out_wr_en[1]),
        .out_din     (out_din[1]),
        .frame_done  (frame_done[1]),
        .frame_count (frame_count[1]),
        .checksum    (checksum[1])
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("[TB] FAIL %s", name);
    endtask

    function automatic int width_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int height_of(input int d);
        return (d == 0) ? H0 : H1;
    endfunction

    // Model: pixel n since reset sits at x = n mod W, y = (n div W) mod H and
    // lands in lane x mod 4; a word closes on lane 3 or on the last column.
    task automatic model_push(input int d, input logic [7:0] p);
        int w;
        int h;
        int px;
        int py;
        logic eol;
        logic eof;
        w  = width_of(d);
        h  = height_of(d);
        px = m_count[d] % w;
        py = (m_count[d] / w) % h;
        in_buf[d][in_tail[d] % N] = p;
        in_tail[d]++;
        m_count[d]++;
        m_word[d] = m_word[d] | ({24'd0, p} << (8 * (px % 4)));
        m_sum[d]  = m_sum[d] + {24'd0, p};
        if ((px % 4 == 3) || (px == w - 1)) begin
            eol = (px == w - 1);
            eof = eol && (py == h - 1);
            if (eof) m_frames[d] = m_frames[d] + 16'd1;
            exp_word[d][exp_tail[d] % N] = {eof, eol, m_word[d]};
            exp_fc[d][exp_tail[d] % N]   = m_frames[d];
`ifdef PACKER_CHECKSUM_EN
            exp_chk[d][exp_tail[d] % N]  = m_sum[d];
`else
            exp_chk[d][exp_tail[d] % N]  = 32'd0;
`endif
            if (eof) m_sum[d] = 32'd0;
            m_word[d] = 32'd0;
            exp_tail[d]++;
        end
    endtask

    task automatic applyStimulus(input int d, input int first, input int count);
        for (int i = 0; i < count; i++) model_push(d, 8'(first + i));
    endtask

    task automatic wait_drain(input int d, input int limit, input string name);
        int n;
        n = 0;
        while (!((in_head[d] == in_tail[d]) && (exp_head[d] == exp_tail[d])) && (n < limit)) begin
            @(posedge clock);
            n++;
        end
        if (n >= limit) fail_now({name, " drain timeout"});
        repeat (3) @(posedge clock);
        #2;
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_tail[d] = exp_head[d];
            m_count[d]  = 0;
            m_word[d]   = 32'd0;
            m_sum[d]    = 32'd0;
            m_frames[d] = 16'd0;
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic checkOutput(input int d, input int base, input int k,
                               input logic [33:0] exp, input string name);
        check($sformatf("%s_w%0d", name, k), 64'(log_word[d][(base + k) % N]), 64'(exp));
    endtask

    // Drive FIFO-side inputs on the falling edge, then check just after it.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            toggle[d]   = ~toggle[d];
            in_empty[d] = (in_head[d] == in_tail[d]) || (gap_mode[d] && toggle[d]);
            in_dout[d]  = (in_head[d] == in_tail[d]) ? 8'h00 : in_buf[d][in_head[d] % N];
            out_full[d] = full_hold[d];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [33:0] e;
            if (!reset) begin
                done_pending[d] = 1'b0;
                fc_hold[d]      = 16'd0;
                chk_hold[d]     = 32'd0;
            end else if (checking) begin
                check($sformatf("excl_%0d", d), 64'(in_rd_en[d] & out_wr_en[d]), 64'd0);
                check($sformatf("rd_empty_%0d", d), 64'(in_rd_en[d] & in_empty[d]), 64'd0);
                check($sformatf("frame_done_%0d", d), 64'(frame_done[d]), 64'(done_pending[d]));
                check($sformatf("frame_count_%0d", d), 64'(frame_count[d]), 64'(fc_hold[d]));
                check($sformatf("checksum_%0d", d), 64'(checksum[d]), 64'(chk_hold[d]));
                done_pending[d] = 1'b0;
                if (out_wr_en[d]) begin
                    if (exp_head[d] == exp_tail[d]) begin
                        fail_now($sformatf("unexpected_word_%0d got %0h", d, out_din[d]));
                    end else begin
                        e = exp_word[d][exp_head[d] % N];
                        check($sformatf("word_%0d", d), 64'(out_din[d]), 64'(e));
                        if (e[33]) begin
                            done_pending[d] = 1'b1;
                            fc_hold[d]      = exp_fc[d][exp_head[d] % N];
                            chk_hold[d]     = exp_chk[d][exp_head[d] % N];
                        end
                        exp_head[d]++;
                    end
                    log_word[d][log_cnt[d] % N] = out_din[d];
                    log_cnt[d]++;
                end
                if (in_rd_en[d]) begin
                    if (in_head[d] == in_tail[d]) fail_now($sformatf("pop_of_empty_%0d", d));
                    else in_head[d]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $display("%0d/%0d checks passed", passed, total);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset values while reset is held low.
        @(posedge clock);
        #2;
        check("rst_out_din", 64'(out_din[0]), 64'd0);
        check("rst_in_rd_en", 64'(in_rd_en[0]), 64'd0);
        check("rst_out_wr_en", 64'(out_wr_en[0]), 64'd0);
        check("rst_frame_done", 64'(frame_done[0]), 64'd0);
        check("rst_frame_count", 64'(frame_count[0]), 64'd0);
        check("rst_checksum", 64'(checksum[0]), 64'd0);
        @(posedge clock);
        #2;
        reset    = 1'b1;
        checking = 1'b1;

        // 8x2 frame, free-flowing.
        base = log_cnt[0];
        applyStimulus(0, 8'h01, 16);
        check("model_w0", 64'(exp_word[0][(exp_head[0] + 0) % N]), 64'(34'h0_04030201));
        check("model_w1", 64'(exp_word[0][(exp_head[0] + 1) % N]), 64'(34'h1_08070605));
        check("model_w2", 64'(exp_word[0][(exp_head[0] + 2) % N]), 64'(34'h0_0C0B0A09));
        check("model_w3", 64'(exp_word[0][(exp_head[0] + 3) % N]), 64'(34'h3_100F0E0D));
        wait_drain(0, 100, "basic");
        checkOutput(0, base, 0, 34'h0_04030201, "basic");
        checkOutput(0, base, 1, 34'h1_08070605, "basic");
        checkOutput(0, base, 2, 34'h0_0C0B0A09, "basic");
        checkOutput(0, base, 3, 34'h3_100F0E0D, "basic");
        check("basic_frame_count", 64'(frame_count[0]), 64'd1);
`ifdef PACKER_CHECKSUM_EN
        check("basic_checksum", 64'(checksum[0]), 64'h88);
`else
        check("basic_checksum", 64'(checksum[0]), 64'h0);
`endif

        // Same frame with the upstream FIFO empty every other cycle.
        gap_mode[0] = 1'b1;
        base = log_cnt[0];
        applyStimulus(0, 8'h01, 16);
        wait_drain(0, 200, "gap");
        checkOutput(0, base, 0, 34'h0_04030201, "gap");
        checkOutput(0, base, 1, 34'h1_08070605, "gap");
        checkOutput(0, base, 2, 34'h0_0C0B0A09, "gap");
        checkOutput(0, base, 3, 34'h3_100F0E0D, "gap");
        check("gap_frame_count", 64'(frame_count[0]), 64'd2);
        gap_mode[0] = 1'b0;

        // Downstream full while the first word is ready.
        full_hold[0] = 1'b1;
        base = log_cnt[0];
        applyStimulus(0, 8'h21, 16);
        repeat (10) @(posedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #2;
            check("stall_rd_en", 64'(in_rd_en[0]), 64'd0);
            check("stall_wr_en", 64'(out_wr_en[0]), 64'd0);
            check("stall_out_din", 64'(out_din[0]), 64'(34'h0_24232221));
            check("stall_pixels_left", 64'(in_tail[0] - in_head[0]), 64'd12);
        end
        full_hold[0] = 1'b0;
        @(negedge clock);
        #2;
        check("stall_release_wr", 64'(out_wr_en[0]), 64'd1);
        wait_drain(0, 100, "stall");
        checkOutput(0, base, 0, 34'h0_24232221, "stall");
        checkOutput(0, base, 1, 34'h1_28272625, "stall");
        checkOutput(0, base, 2, 34'h0_2C2B2A29, "stall");
        checkOutput(0, base, 3, 34'h3_302F2E2D, "stall");
        check("stall_frame_count", 64'(frame_count[0]), 64'd3);

        // Reset after three pixels of a frame: they must vanish.
        base = log_cnt[0];
        applyStimulus(0, 8'h51, 3);
        n = 0;
        while ((in_head[0] != in_tail[0]) && (n < 20)) begin
            @(posedge clock);
            n++;
        end
        if (n >= 20) fail_now("midreset pop timeout");
        apply_reset();
        check("midreset_frame_count", 64'(frame_count[0]), 64'd0);
        check("midreset_out_din", 64'(out_din[0]), 64'd0);
        check("midreset_no_words", 64'(log_cnt[0] - base), 64'd0);
        applyStimulus(0, 8'h01, 16);
        wait_drain(0, 100, "midreset");
        checkOutput(0, base, 0, 34'h0_04030201, "midreset");
        checkOutput(0, base, 1, 34'h1_08070605, "midreset");
        checkOutput(0, base, 2, 34'h0_0C0B0A09, "midreset");
        checkOutput(0, base, 3, 34'h3_100F0E0D, "midreset");
        check("midreset_frame_count_end", 64'(frame_count[0]), 64'd1);

        // 6x1 frame: padded final word carries both tags.
        base = log_cnt[1];
        applyStimulus(1, 8'hA0, 6);
        check("model6_w0", 64'(exp_word[1][(exp_head[1] + 0) % N]), 64'(34'h0_A3A2A1A0));
        check("model6_w1", 64'(exp_word[1][(exp_head[1] + 1) % N]), 64'(34'h3_0000A5A4));
        wait_drain(1, 100, "pad");
        checkOutput(1, base, 0, 34'h0_A3A2A1A0, "pad");
        checkOutput(1, base, 1, 34'h3_0000A5A4, "pad");
        check("pad_frame_count", 64'(frame_count[1]), 64'd1);
`ifdef PACKER_CHECKSUM_EN
        check("pad_checksum", 64'(checksum[1]), 64'h3CF);
`else
        check("pad_checksum", 64'(checksum[1]), 64'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
